// File: rtl/mc_res.sv
// Residual generator: original minus motion-compensated prediction, plus a per-block SAD.
// Latency: 2 cycles from a pre_wr beat to res_*; res_last_o and sad_o are aligned with the block's last beat.
// No backpressure: one beat per cycle sustained, and the consumer must accept every res_val_o beat.
module mc_res #(
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           pre_wr_ena_i,
    input  logic [1:0]                     pre_wr_sel_i,
    input  logic [1:0]                     pre_wr_siz_i,
    input  logic [3:0]                     pre_wr_4x4_x_i,
    input  logic [3:0]                     pre_wr_4x4_y_i,
    input  logic [32*PIXEL_WIDTH-1:0]      pre_wr_dat_i,
    output logic                           ori_rd_ena_o,
    output logic [1:0]                     ori_rd_sel_o,
    output logic [1:0]                     ori_rd_siz_o,
    output logic [3:0]                     ori_rd_4x4_x_o,
    output logic [3:0]                     ori_rd_4x4_y_o,
    input  logic [32*PIXEL_WIDTH-1:0]      ori_rd_dat_i,
    output logic                           res_val_o,
    output logic [1:0]                     res_sel_o,
    output logic [1:0]                     res_siz_o,
    output logic [3:0]                     res_4x4_x_o,
    output logic [3:0]                     res_4x4_y_o,
    output logic [32*(PIXEL_WIDTH+1)-1:0]  res_dat_o,
    output logic                           res_last_o,
    output logic                           sad_val_o,
    output logic [PIXEL_WIDTH+9:0]         sad_o
);

    localparam int PW    = PIXEL_WIDTH;
    localparam int RW    = PIXEL_WIDTH + 1;
    localparam int SW    = PIXEL_WIDTH + 10;
    localparam int LANES = 32;

    localparam logic [1:0] SIZE_04 = 2'd0;
    localparam logic [1:0] SIZE_08 = 2'd1;
    localparam logic [1:0] SIZE_16 = 2'd2;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    function automatic logic [5:0] beats_of(input logic [1:0] siz);
        case (siz)
            SIZE_04: beats_of = 6'd1;
            SIZE_08: beats_of = 6'd2;
            SIZE_16: beats_of = 6'd8;
            default: beats_of = 6'd32;
        endcase
    endfunction

    // Original-buffer read shares the prediction write address so data lands alongside stage 1
    assign ori_rd_ena_o   = pre_wr_ena_i;
    assign ori_rd_sel_o   = pre_wr_sel_i;
    assign ori_rd_siz_o   = pre_wr_siz_i;
    assign ori_rd_4x4_x_o = pre_wr_4x4_x_i;
    assign ori_rd_4x4_y_o = pre_wr_4x4_y_i;

    logic                 s1_vld;
    logic [1:0]           s1_sel;
    logic [1:0]           s1_siz;
    logic [3:0]           s1_x;
    logic [3:0]           s1_y;
    logic [32*PW-1:0]     s1_pre;

    logic [0:0]           state;
    logic [5:0]           cnt;
    logic [1:0]           blk_siz;
    logic [SW-1:0]        acc;

    logic [1:0]           eff_siz;
    logic [5:0]           cnt_nxt;
    logic                 beat_last;
    logic [RW-1:0]        lane_diff;
    logic [RW-1:0]        lane_abs;
    logic [LANES*RW-1:0]  res_comb;
    logic [SW-1:0]        beat_sum;

    // Stage 1: hold the prediction beat while the original-buffer read completes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vld <= 1'b0;
            s1_sel <= '0;
            s1_siz <= '0;
            s1_x   <= '0;
            s1_y   <= '0;
            s1_pre <= '0;
        end else begin
            s1_vld <= pre_wr_ena_i;
            if (pre_wr_ena_i) begin
                s1_sel <= pre_wr_sel_i;
                s1_siz <= pre_wr_siz_i;
                s1_x   <= pre_wr_4x4_x_i;
                s1_y   <= pre_wr_4x4_y_i;
                s1_pre <= pre_wr_dat_i;
            end
        end
    end

    // Block length comes from the size latched on the first beat; mid-block size changes do not count
    always_comb begin
        eff_siz   = (state == ST_IDLE) ? s1_siz : blk_siz;
        cnt_nxt   = (state == ST_IDLE) ? 6'd1 : cnt + 6'd1;
        beat_last = s1_vld && (cnt_nxt == beats_of(eff_siz));
    end

    // Per-lane residual and beat SAD; a 4x4 beat only carries pixels in the lower 16 lanes
    always_comb begin
        res_comb  = '0;
        beat_sum  = '0;
        lane_diff = '0;
        lane_abs  = '0;
        for (int i = 0; i < LANES; i++) begin
            if ((i < LANES / 2) || (eff_siz != SIZE_04)) begin
                lane_diff = {1'b0, ori_rd_dat_i[i*PW +: PW]} - {1'b0, s1_pre[i*PW +: PW]};
                lane_abs  = lane_diff[PW] ? (~lane_diff + RW'(1)) : lane_diff;
                res_comb[i*RW +: RW] = lane_diff;
                beat_sum  = beat_sum + SW'(lane_abs);
            end
        end
    end

    // Block FSM and SAD accumulator; the accumulator clears on the last beat so blocks can abut
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            blk_siz <= '0;
            acc     <= '0;
        end else if (s1_vld) begin
            if (state == ST_IDLE) begin
                blk_siz <= s1_siz;
            end
            if (beat_last) begin
                state <= ST_IDLE;
                cnt   <= '0;
                acc   <= '0;
            end else begin
                state <= ST_ACTIVE;
                cnt   <= cnt_nxt;
                acc   <= acc + beat_sum;
            end
        end
    end

    // Stage 2: residual beat, last marker and completed-block SAD
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_val_o   <= 1'b0;
            res_sel_o   <= '0;
            res_siz_o   <= '0;
            res_4x4_x_o <= '0;
            res_4x4_y_o <= '0;
            res_dat_o   <= '0;
            res_last_o  <= 1'b0;
            sad_val_o   <= 1'b0;
            sad_o       <= '0;
        end else begin
            res_val_o  <= s1_vld;
            res_last_o <= beat_last;
            sad_val_o  <= beat_last;
            if (s1_vld) begin
                res_sel_o   <= s1_sel;
                res_siz_o   <= s1_siz;
                res_4x4_x_o <= s1_x;
                res_4x4_y_o <= s1_y;
                res_dat_o   <= res_comb;
            end
            if (beat_last) begin
                sad_o <= acc + beat_sum;
            end
        end
    end

endmodule
